// File: rtl/note_search.sv
// Reverse note-table lookup: successive-approximation search for the largest entry <= the query.
// Define NOTE_SEARCH_ROUND_EN to snap to the nearer of the floor entry and the next entry.
module note_search #(
  parameter int DATA_WDTH = 16,
  parameter int ADDR_WDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WDTH-1:0] in_value,
  output logic [ADDR_WDTH-1:0] rom_addr,
  input  logic [DATA_WDTH-1:0] rom_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_WDTH-1:0] out_note,
  output logic                 out_exact,
  output logic                 out_under
);

`ifdef NOTE_SEARCH_ROUND_EN
  localparam bit ROUND_EN = 1'b1;
`else
  localparam bit ROUND_EN = 1'b0;
`endif

  localparam int BIT_W = (ADDR_WDTH > 1) ? $clog2(ADDR_WDTH) : 1;
  localparam logic [BIT_W-1:0]     TOP_BIT  = BIT_W'(ADDR_WDTH - 1);
  localparam logic [BIT_W-1:0]     ZERO_BIT = BIT_W'(0);
  localparam logic [ADDR_WDTH-1:0] ONE_A    = ADDR_WDTH'(1);
  localparam logic [ADDR_WDTH-1:0] ZERO_A   = ADDR_WDTH'(0);
  localparam logic [ADDR_WDTH-1:0] ALL_A    = {ADDR_WDTH{1'b1}};
  localparam logic [DATA_WDTH-1:0] ZERO_D   = DATA_WDTH'(0);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_CMP   = 3'd2,
    ST_DONE  = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RCMP  = 3'd5
  } state_t;

  state_t                 state_r, state_nx_s;
  logic [DATA_WDTH-1:0]   value_r, value_nx_s;
  logic [DATA_WDTH-1:0]   floor_r, floor_nx_s;
  logic [ADDR_WDTH-1:0]   result_r, result_nx_s;
  logic [ADDR_WDTH-1:0]   addr_r, addr_nx_s;
  logic [BIT_W-1:0]       bit_r, bit_nx_s;
  logic                   first_r, first_nx_s;
  logic                   exact_r, exact_nx_s;
  logic                   under_r, under_nx_s;
  logic                   in_ready_r;
  logic                   out_valid_r;

  logic [ADDR_WDTH-1:0]   mask_s;
  logic [ADDR_WDTH-1:0]   cand_s;
  logic [ADDR_WDTH-1:0]   sel_s;
  logic                   le_s;
  logic                   eq_s;
  logic                   last_s;
  logic                   round_go_s;
  logic                   closer_s;

  // Candidate index and compare results shared by next-state and datapath logic.
  assign mask_s     = ONE_A << bit_r;
  assign cand_s     = result_r | mask_s;
  assign le_s       = (rom_data <= value_r);
  assign eq_s       = (rom_data == value_r);
  assign sel_s      = le_s ? cand_s : result_r;
  assign last_s     = (bit_r == ZERO_BIT);
  assign round_go_s = ROUND_EN && (sel_s != ALL_A);
  // Upper neighbour wins only when strictly closer, so ties keep the floor index.
  assign closer_s   = ((rom_data - value_r) < (value_r - floor_r));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) state_nx_s = ST_WAIT;
        else                        state_nx_s = ST_IDLE;
      end
      ST_WAIT: state_nx_s = ST_CMP;
      ST_CMP: begin
        if (first_r) begin
          if (!le_s) state_nx_s = ST_DONE;
          else       state_nx_s = ST_WAIT;
        end else if (!last_s) begin
          state_nx_s = ST_WAIT;
        end else if (round_go_s) begin
          state_nx_s = ST_RWAIT;
        end else begin
          state_nx_s = ST_DONE;
        end
      end
      ST_RWAIT: state_nx_s = ST_RCMP;
      ST_RCMP:  state_nx_s = ST_DONE;
      ST_DONE: begin
        if (out_ready) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Datapath next values: latch query, walk candidate bits, optional rounding step.
  always_comb begin
    value_nx_s  = value_r;
    floor_nx_s  = floor_r;
    result_nx_s = result_r;
    addr_nx_s   = addr_r;
    bit_nx_s    = bit_r;
    first_nx_s  = first_r;
    exact_nx_s  = exact_r;
    under_nx_s  = under_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid && in_ready_r) begin
          value_nx_s  = in_value;
          floor_nx_s  = ZERO_D;
          result_nx_s = ZERO_A;
          addr_nx_s   = ZERO_A;
          bit_nx_s    = ZERO_BIT;
          first_nx_s  = 1'b1;
          exact_nx_s  = 1'b0;
          under_nx_s  = 1'b0;
        end else begin
          value_nx_s = value_r;
        end
      end
      ST_CMP: begin
        first_nx_s = 1'b0;
        if (first_r) begin
          if (!le_s) begin
            result_nx_s = ZERO_A;
            under_nx_s  = 1'b1;
            exact_nx_s  = 1'b0;
          end else begin
            exact_nx_s = eq_s;
            floor_nx_s = rom_data;
            bit_nx_s   = TOP_BIT;
            addr_nx_s  = result_r | (ONE_A << TOP_BIT);
          end
        end else begin
          result_nx_s = sel_s;
          if (le_s) begin
            exact_nx_s = eq_s;
            floor_nx_s = rom_data;
          end else begin
            exact_nx_s = exact_r;
          end
          if (!last_s) begin
            bit_nx_s  = bit_r - BIT_W'(1);
            addr_nx_s = sel_s | (mask_s >> 1);
          end else if (round_go_s) begin
            addr_nx_s = sel_s + ONE_A;
          end else begin
            addr_nx_s = addr_r;
          end
        end
      end
      ST_RCMP: begin
        if (closer_s) begin
          result_nx_s = result_r + ONE_A;
          exact_nx_s  = eq_s;
        end else begin
          result_nx_s = result_r;
        end
      end
      ST_WAIT, ST_RWAIT, ST_DONE: begin
        value_nx_s = value_r;
      end
      default: begin
        value_nx_s = value_r;
      end
    endcase
  end

  // Datapath and handshake registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_r     <= ZERO_D;
      floor_r     <= ZERO_D;
      result_r    <= ZERO_A;
      addr_r      <= ZERO_A;
      bit_r       <= ZERO_BIT;
      first_r     <= 1'b0;
      exact_r     <= 1'b0;
      under_r     <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      value_r     <= value_nx_s;
      floor_r     <= floor_nx_s;
      result_r    <= result_nx_s;
      addr_r      <= addr_nx_s;
      bit_r       <= bit_nx_s;
      first_r     <= first_nx_s;
      exact_r     <= exact_nx_s;
      under_r     <= under_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign rom_addr  = addr_r;
  assign out_note  = result_r;
  assign out_exact = exact_r;
  assign out_under = under_r;

endmodule
